heap_server: RTL and testbench

HEAP_SERVER -- requirements
Module: heap_server

---
 rtl/heap_pkg.sv | 37 +++
 rtl/heap_server_if.sv | 24 ++
 rtl/heap_ram.sv | 18 +
 rtl/heap_server.sv | 161 ++++++++++++++++
 tb/tb_heap_server.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/heap_pkg.sv
// Shared types and default sizing for the heap server: action codes, error codes and FSM states.
package heap_pkg;

  localparam int DEF_WIDTH     = 12;
  localparam int DEF_NARRAYS   = 4;
  localparam int DEF_ARRAY_LEN = 8;

  typedef enum logic [7:0] {
    ACT_NOP    = 8'd0,
    ACT_ALLOC  = 8'd1,
    ACT_FREE   = 8'd2,
    ACT_READ   = 8'd3,
    ACT_WRITE  = 8'd4,
    ACT_PUSH   = 8'd5,
    ACT_POP    = 8'd6,
    ACT_SIZE   = 8'd7,
    ACT_RESIZE = 8'd8
  } action_e;

  typedef enum logic [31:0] {
    ERR_OK          = 32'd0,
    ERR_BAD_ACTION  = 32'd1,
    ERR_NOT_ALLOC   = 32'd2,
    ERR_INDEX       = 32'd3,
    ERR_FULL        = 32'd4,
    ERR_EMPTY       = 32'd5,
    ERR_NO_FREE     = 32'd6,
    ERR_RESIZE      = 32'd7
  } error_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/heap_server_if.sv
// Request/response bundle between a client (master) and the heap server (slave).
interface heap_server_if import heap_pkg::*; #(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int NARRAYS   = DEF_NARRAYS,
  parameter int ARRAY_LEN = DEF_ARRAY_LEN
);
  localparam int AW = $clog2(NARRAYS);
  localparam int IW = $clog2(ARRAY_LEN);

  logic             req;
  logic [7:0]       action;
  logic [AW-1:0]    array;
  logic [IW-1:0]    index;
  logic [WIDTH-1:0] in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;
  logic [31:0]      error;

  modport master (output req, action, array, index, in,
                  input  busy, done, out, error);
  modport slave  (input  req, action, array, index, in,
                  output busy, done, out, error);
endinterface

// File: rtl/heap_ram.sv
// Single-port word store addressed by {array,index}; read data is registered.
module heap_ram #(
  parameter int WIDTH = 12,
  parameter int ABITS = 5
) (
  input  logic             clock,
  input  logic             we,
  input  logic [ABITS-1:0] addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [2**ABITS];

  always_ff @(posedge clock) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end
endmodule

// File: rtl/heap_server.sv
// Heap server: three-state FSM, allocation bitmap, per-array sizes and error checking
// in front of a shared word RAM. Results publish with done two edges after accept.
module heap_server import heap_pkg::*; #(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int NARRAYS   = DEF_NARRAYS,
  parameter int ARRAY_LEN = DEF_ARRAY_LEN
) (
  input logic         clock,
  input logic         reset,
  heap_server_if.slave bus
);
  localparam int AW = $clog2(NARRAYS);
  localparam int IW = $clog2(ARRAY_LEN);
  localparam int SW = IW + 1;

  state_e           state;
  action_e          actL;
  logic [AW-1:0]    arrL;
  logic [IW-1:0]    idxL;
  logic [WIDTH-1:0] inL;
  logic [NARRAYS-1:0] allocd;
  logic [SW-1:0]    sizes [NARRAYS];
  logic [31:0]      errP;
  logic [WIDTH-1:0] resP;
  logic             busy, done;
  logic [WIDTH-1:0] out;
  logic [31:0]      error;

  logic [SW-1:0]    curSize;
  logic             freeFound;
  logic [AW-1:0]    freeIdx;
  logic [31:0]      errC;
  logic [WIDTH-1:0] resC;
  logic [IW-1:0]    ramIdx;
  logic             ramWe;
  logic [WIDTH-1:0] rdata;

  assign curSize = sizes[arrL];

  // Lowest-numbered free array wins.
  always_comb begin
    freeFound = 1'b0;
    freeIdx   = '0;
    for (int i = NARRAYS - 1; i >= 0; i--) begin
      if (!allocd[i]) begin
        freeFound = 1'b1;
        freeIdx   = AW'(i);
      end
    end
  end

  always_comb begin
    errC = ERR_OK;
    if (actL > ACT_RESIZE) errC = ERR_BAD_ACTION;
    else if (actL != ACT_NOP && actL != ACT_ALLOC && !allocd[arrL]) errC = ERR_NOT_ALLOC;
    else begin
      case (actL)
        ACT_ALLOC:  if (!freeFound) errC = ERR_NO_FREE;
        ACT_READ,
        ACT_WRITE:  if ({1'b0, idxL} >= curSize) errC = ERR_INDEX;
        ACT_PUSH:   if (curSize == SW'(ARRAY_LEN)) errC = ERR_FULL;
        ACT_POP:    if (curSize == '0) errC = ERR_EMPTY;
        ACT_RESIZE: if ({1'b0, idxL} > SW'(ARRAY_LEN)) errC = ERR_RESIZE;
        default:    errC = ERR_OK;
      endcase
    end
  end

  always_comb begin
    resC   = '0;
    ramIdx = idxL;
    case (actL)
      ACT_ALLOC: resC = WIDTH'(freeIdx);
      ACT_WRITE: resC = inL;
      ACT_PUSH: begin
        resC   = WIDTH'(curSize + 1'b1);
        ramIdx = IW'(curSize);
      end
      ACT_POP:   ramIdx = IW'(curSize - 1'b1);
      ACT_SIZE:  resC = WIDTH'(curSize);
      default:   resC = '0;
    endcase
  end

  // A reset edge landing on the commit edge must not write storage.
  assign ramWe = (state == EXEC) && !reset && (errC == ERR_OK) &&
                 (actL == ACT_WRITE || actL == ACT_PUSH);

  heap_ram #(.WIDTH(WIDTH), .ABITS(AW + IW)) uRam (
    .clock (clock),
    .we    (ramWe),
    .addr  ({arrL, ramIdx}),
    .wdata (inL),
    .rdata (rdata)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      out    <= '0;
      error  <= '0;
      allocd <= '0;
      for (int i = 0; i < NARRAYS; i++) sizes[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (bus.req && !busy) begin
            actL  <= action_e'(bus.action);
            arrL  <= bus.array;
            idxL  <= bus.index;
            inL   <= bus.in;
            busy  <= 1'b1;
            state <= EXEC;
          end else begin
            busy <= 1'b0;
          end
        end
        // EXEC: commit bookkeeping; RAM read of the target word lands for RESP.
        EXEC: begin
          errP  <= errC;
          resP  <= resC;
          state <= RESP;
          if (errC == ERR_OK) begin
            case (actL)
              ACT_ALLOC: begin
                allocd[freeIdx] <= 1'b1;
                sizes[freeIdx]  <= '0;
              end
              ACT_FREE: begin
                allocd[arrL] <= 1'b0;
                sizes[arrL]  <= '0;
              end
              ACT_PUSH:   sizes[arrL] <= curSize + 1'b1;
              ACT_POP:    sizes[arrL] <= curSize - 1'b1;
              ACT_RESIZE: sizes[arrL] <= {1'b0, idxL};
              default: ;
            endcase
          end
        end
        // RESP: publish the response; done shows in the following cycle.
        RESP: begin
          done  <= 1'b1;
          error <= errP;
          if (errP != ERR_OK)                          out <= '0;
          else if (actL == ACT_READ || actL == ACT_POP) out <= rdata;
          else                                         out <= resP;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy  = busy;
  assign bus.done  = done;
  assign bus.out   = out;
  assign bus.error = error;
endmodule

// File: tb/tb_heap_server.sv
// Directed table-driven bench for heap_server with hand-written timing and reset sequences.
module tb_heap_server;
  import heap_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clock = ~clock;

  heap_server_if #(.WIDTH(12), .NARRAYS(4), .ARRAY_LEN(8)) bus ();

  heap_server #(.WIDTH(12), .NARRAYS(4), .ARRAY_LEN(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int act;
    int arr;
    int idx;
    int din;
    int expOut;
    int expErr;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  // One request; returns response once done is seen, bounded to a few cycles.
  task automatic doOp(input int a, input int arr, input int idx, input int din,
                      output int o, output int e, output bit ok);
    @(negedge clock);
    bus.req    = 1'b1;
    bus.action = 8'(a);
    bus.array  = 2'(arr);
    bus.index  = 3'(idx);
    bus.in     = 12'(din);
    @(negedge clock);
    bus.req = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (bus.done) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
    o = int'(bus.out);
    e = int'(bus.error);
  endtask

  task automatic opChk(input string name, input int a, input int arr, input int idx,
                       input int din, input int expOut, input int expErr);
    int o, e;
    bit ok;
    doOp(a, arr, idx, din, o, e, ok);
    chk({name, " done"}, int'(ok), 1);
    chk({name, " out"}, o, expOut);
    chk({name, " error"}, e, expErr);
  endtask

  initial begin
    bus.req = 1'b0; bus.action = '0; bus.array = '0; bus.index = '0; bus.in = '0;

    vecs.push_back('{1, 0, 0, 0,     0,     0});   // ALLOC -> 0
    vecs.push_back('{1, 0, 0, 0,     1,     0});   // ALLOC -> 1
    vecs.push_back('{1, 0, 0, 0,     2,     0});   // ALLOC -> 2
    vecs.push_back('{2, 1, 0, 0,     0,     0});   // FREE 1
    vecs.push_back('{1, 0, 0, 0,     1,     0});   // ALLOC -> 1 again
    vecs.push_back('{5, 1, 0, 5,     1,     0});   // PUSH 5
    vecs.push_back('{5, 1, 0, 7,     2,     0});   // PUSH 7
    vecs.push_back('{6, 1, 0, 0,     7,     0});   // POP -> 7
    vecs.push_back('{7, 1, 0, 0,     1,     0});   // SIZE -> 1
    vecs.push_back('{3, 1, 0, 0,     5,     0});   // READ [1][0] -> 5
    vecs.push_back('{3, 3, 0, 0,     0,     2});   // READ unallocated
    vecs.push_back('{9, 3, 0, 0,     0,     1});   // bad action beats not-allocated
    vecs.push_back('{5, 2, 0, 'hABC, 1,     0});
    vecs.push_back('{5, 2, 0, 'h123, 2,     0});
    vecs.push_back('{3, 2, 3, 0,     0,     3});   // index 3 with size 2
    vecs.push_back('{4, 2, 1, 'h456, 'h456, 0});   // WRITE
    vecs.push_back('{3, 2, 1, 0,     'h456, 0});   // READ back
    vecs.push_back('{3, 2, 0, 0,     'hABC, 0});
    vecs.push_back('{6, 0, 0, 0,     0,     5});   // POP empty
    vecs.push_back('{8, 2, 7, 0,     0,     0});   // RESIZE to 7
    vecs.push_back('{7, 2, 0, 0,     7,     0});
    vecs.push_back('{4, 2, 7, 0,     0,     3});   // index 7 with size 7
    vecs.push_back('{0, 0, 0, 0,     0,     0});   // NOP
    vecs.push_back('{1, 0, 0, 0,     3,     0});   // ALLOC -> 3
    vecs.push_back('{1, 0, 0, 0,     0,     6});   // none free
    vecs.push_back('{2, 3, 0, 0,     0,     0});   // FREE 3
    vecs.push_back('{2, 3, 0, 0,     0,     2});   // FREE again -> not allocated

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset busy", int'(bus.busy), 0);
    chk("reset done", int'(bus.done), 0);
    chk("reset out", int'(bus.out), 0);
    chk("reset error", int'(bus.error), 0);
    reset = 1'b0;

    for (int v = 0; v < vecs.size(); v++)
      opChk($sformatf("vec%0d", v), vecs[v].act, vecs[v].arr, vecs[v].idx,
            vecs[v].din, vecs[v].expOut, vecs[v].expErr);

    // Fill array 0 to capacity, then overflow.
    for (int k = 0; k < 8; k++)
      opChk($sformatf("fill%0d", k), 5, 0, 0, 10 + k, k + 1, 0);
    opChk("push full", 5, 0, 0, 99, 0, 4);
    opChk("size after full", 7, 0, 0, 0, 8, 0);
    opChk("pop top", 6, 0, 0, 0, 17, 0);

    // Second req one cycle after accept is ignored, and inputs are latched.
    @(negedge clock);
    bus.req = 1'b1; bus.action = 8'd7; bus.array = 2'd0;
    @(negedge clock);
    chk("t1 busy", int'(bus.busy), 1);
    chk("t1 done", int'(bus.done), 0);
    bus.action = 8'd2;
    @(negedge clock);
    bus.req = 1'b0;
    chk("t2 busy", int'(bus.busy), 1);
    chk("t2 done", int'(bus.done), 0);
    @(negedge clock);
    chk("t3 busy", int'(bus.busy), 1);
    chk("t3 done", int'(bus.done), 1);
    chk("t3 out", int'(bus.out), 7);
    @(negedge clock);
    chk("t4 busy", int'(bus.busy), 0);
    chk("t4 done", int'(bus.done), 0);
    begin
      int extraDone = 0;
      for (int k = 0; k < 5; k++) begin
        @(negedge clock);
        if (bus.done) extraDone++;
      end
      chk("no queued done", extraDone, 0);
    end
    opChk("size kept", 7, 0, 0, 0, 7, 0);

    // Reset while a PUSH is in EXEC aborts it.
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    opChk("post-reset alloc", 1, 0, 0, 0, 0, 0);
    @(negedge clock);
    bus.req = 1'b1; bus.action = 8'd5; bus.array = 2'd0; bus.in = 12'd33;
    @(negedge clock);
    bus.req = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    begin
      int abortDone = 0;
      for (int k = 0; k < 4; k++) begin
        if (bus.done) abortDone++;
        @(negedge clock);
      end
      chk("abort no done", abortDone, 0);
    end
    opChk("abort array free", 7, 0, 0, 0, 0, 2);
    opChk("abort realloc", 1, 0, 0, 0, 0, 0);
    opChk("abort size", 7, 0, 0, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
